// File: rtl/operand_pkg.sv
// Shared types and helpers for the operand skid stage: state encoding,
// the default-width operand bundle and the stall-counter ceiling.
package operand_pkg;

    localparam int OPERAND_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic                     a;
        logic [OPERAND_WIDTH-1:0] c;
        logic [OPERAND_WIDTH-1:0] d;
        logic [OPERAND_WIDTH-1:0] e;
    } operand_bundle_t;

    // Largest value a cnt_w-bit counter can hold; widths of 32 or more clamp to 32 bits.
    function automatic int unsigned STALL_CNT_MAX(input int unsigned cnt_w);
        if (cnt_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/operand_skid_stage.sv
// Two-entry valid/ready skid stage holding the operand bundle for the selector,
// with a registered ready and a saturating back-pressure counter.
module operand_skid_stage
    import operand_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_a,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_e,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_a,
    output logic [WIDTH-1:0] o_c,
    output logic [WIDTH-1:0] o_d,
    output logic [WIDTH-1:0] o_e,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CNT_MAX(CNT_W));

    // Same layout as operand_bundle_t, but following this instance's WIDTH.
    typedef struct packed {
        logic             a;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e;
    } bundle_t;

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             ready_q;
    logic             valid_q;
    bundle_t          main_q;
    bundle_t          skid_q;
    bundle_t          in_bundle;
    logic [CNT_W-1:0] stall_q;
    logic             xfer_in;
    logic             xfer_out;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign xfer_in   = i_valid && ready_q;
    assign xfer_out  = valid_q && i_ready;
    assign in_bundle = '{a: i_a, c: i_c, d: i_d, e: i_e};

    // Handshake flags are decoded from the next state so both leave a flop.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
            valid_q <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (xfer_in) state_d = ONE;
            end
            ONE: begin
                if (xfer_in && !xfer_out)      state_d = FULL;
                else if (!xfer_in && xfer_out) state_d = EMPTY;
            end
            FULL: begin
                if (xfer_out) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: load_main = xfer_in;
            ONE: begin
                load_main = xfer_in && xfer_out;
                load_skid = xfer_in && !xfer_out;
            end
            FULL: begin
                load_main      = xfer_out;
                main_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) main_q <= main_from_skid ? skid_q : in_bundle;
            if (load_skid) skid_q <= in_bundle;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stall_q <= '0;
        end else if (valid_q && !i_ready && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_a         = main_q.a;
    assign o_c         = main_q.c;
    assign o_d         = main_q.d;
    assign o_e         = main_q.e;
    assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_skid_stage.sv
// Self-checking bench for operand_skid_stage: directed scenarios plus random
// valid/ready traffic compared against a queue-based reference model.
module tb_operand_skid_stage;

    localparam int WIDTH     = 8;
    localparam int CNT_W     = 4;
    localparam int BW        = 1 + 3 * WIDTH;
    localparam int STALL_SAT = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_arst_n;
    logic             i_valid;
    logic             o_ready;
    logic             i_a;
    logic [WIDTH-1:0] i_c;
    logic [WIDTH-1:0] i_d;
    logic [WIDTH-1:0] i_e;
    logic             o_valid;
    logic             i_ready;
    logic             o_a;
    logic [WIDTH-1:0] o_c;
    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_e;
    logic [CNT_W-1:0] o_stall_cnt;

    logic [BW-1:0] exp_q[$];
    int            exp_stall;
    int            checks;
    int            errors;

    always #5 i_clk = ~i_clk;

    operand_skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_c         (i_c),
        .i_d         (i_d),
        .i_e         (i_e),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_a         (o_a),
        .o_c         (o_c),
        .o_d         (o_d),
        .o_e         (o_e),
        .o_stall_cnt (o_stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [BW-1:0] mkBundle(input logic [7:0] cv);
        return {cv[0], cv, ~cv, cv ^ 8'h5A};
    endfunction

    // The stage is a two-deep FIFO: valid means non-empty, ready means room left.
    task automatic checkModel();
        checkOutput("o_valid", 32'(exp_q.size() > 0), 32'(o_valid) == 0 ? 32'(o_valid) : 32'(o_valid));
    endtask

    task automatic checkState();
        checkOutput("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
        checkOutput("o_ready", 32'(o_ready), 32'(exp_q.size() < 2));
        checkOutput("o_stall_cnt", 32'(o_stall_cnt), 32'(exp_stall));
        if (exp_q.size() > 0) begin
            checkOutput("bundle", 32'({o_a, o_c, o_d, o_e}), 32'(exp_q[0]));
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [BW-1:0] bundle, input logic ready);
        int n;
        bit accept;
        bit release_head;
        i_valid = valid;
        {i_a, i_c, i_d, i_e} = bundle;
        i_ready = ready;
        checkState();
        n            = exp_q.size();
        accept       = valid && (n < 2);
        release_head = (n > 0) && ready;
        @(posedge i_clk);
        if ((n > 0) && !ready && (exp_stall < STALL_SAT)) exp_stall++;
        if (release_head) void'(exp_q.pop_front());
        if (accept) exp_q.push_back(bundle);
        @(negedge i_clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        i_arst_n  = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        {i_a, i_c, i_d, i_e} = '0;
        repeat (2) @(negedge i_clk);

        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_cnt", 32'(o_stall_cnt), 32'd0);
        checkOutput("rst_bundle", 32'({o_a, o_c, o_d, o_e}), 32'd0);
        i_arst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] streaming");
        for (int k = 1; k <= 16; k++) applyStimulus(1'b1, mkBundle(8'(k)), 1'b1);
        repeat (2) applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, mkBundle(8'hA1), 1'b0);
        applyStimulus(1'b1, mkBundle(8'hA2), 1'b0);
        applyStimulus(1'b1, mkBundle(8'hA3), 1'b0);
        checkOutput("bp_head", 32'(o_c), 32'hA1);
        checkOutput("bp_ready", 32'(o_ready), 32'd0);
        applyStimulus(1'b1, mkBundle(8'hA3), 1'b1);
        checkOutput("bp_second", 32'(o_c), 32'hA2);
        applyStimulus(1'b1, mkBundle(8'hA3), 1'b1);
        checkOutput("bp_third", 32'(o_c), 32'hA3);
        repeat (2) applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] simultaneous in/out");
        applyStimulus(1'b1, mkBundle(8'h55), 1'b0);
        applyStimulus(1'b1, mkBundle(8'h66), 1'b1);
        checkOutput("sim_data", 32'(o_c), 32'h66);
        checkOutput("sim_valid", 32'(o_valid), 32'd1);
        checkOutput("sim_ready", 32'(o_ready), 32'd1);
        repeat (2) applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] counter saturation");
        applyStimulus(1'b1, mkBundle(8'h77), 1'b0);
        repeat (20) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("sat_cnt", 32'(o_stall_cnt), 32'(STALL_SAT));
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("sat_hold", 32'(o_stall_cnt), 32'(STALL_SAT));
        repeat (2) applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, mkBundle(8'h31), 1'b0);
        applyStimulus(1'b1, mkBundle(8'h32), 1'b0);
        #2;
        i_arst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(o_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(o_ready), 32'd1);
        checkOutput("mid_rst_cnt", 32'(o_stall_cnt), 32'd0);
        checkOutput("mid_rst_data", 32'(o_c), 32'd0);
        exp_q.delete();
        exp_stall = 0;
        i_valid   = 1'b0;
        @(negedge i_clk);
        i_arst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), BW'($urandom), 1'($urandom_range(0, 9) < 7));
        end
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drained", 32'(o_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_skid_stage.md
# operand_skid_stage

Registered valid/ready skid stage that captures the operand bundle (select `a`, data `c`, `d`, `e`) and presents it to the downstream combinational selector stage that computes `b`. It decouples upstream timing from the selector's always_comb path, sustains one transfer per cycle, and keeps its ready output registered. A saturating counter records downstream back-pressure cycles for debug.

## Interface
- `WIDTH`, 8: width of each data operand `c`, `d`, `e`.
- `CNT_W`, 16: width of the back-pressure counter.
- `i_clk` input 1: clock, rising-edge.
- `i_arst_n` input 1: asynchronous active-low reset.
- `i_valid` input 1: upstream operand bundle valid.
- `o_ready` output 1: stage can accept; registered.
- `i_a` input 1: select operand.
- `i_c`, `i_d`, `i_e` input WIDTH: data operands.
- `o_valid` output 1: bundle valid toward selector.
- `i_ready` input 1: selector/consumer ready.
- `o_a` output 1, `o_c`/`o_d`/`o_e` output WIDTH: registered bundle.
- `o_stall_cnt` output CNT_W: saturating count of cycles with `o_valid && !i_ready`.

## Operation
- Transfer in: `i_valid && o_ready` at a rising edge. Transfer out: `o_valid && i_ready`.
- Storage: main register (drives outputs) plus one skid register.
- States: EMPTY (no entries), ONE (main full), FULL (main and skid full).
- EMPTY: in -> ONE, bundle loads main.
- ONE: in with no out -> FULL, bundle loads skid. In and out -> ONE, bundle loads main. Out with no in -> EMPTY.
- FULL: out -> ONE, skid moves to main. No out -> FULL, no change. In cannot occur because `o_ready` is 0.
- `o_ready` = 1 in EMPTY and ONE, 0 in FULL. It is the registered next-state decode, not combinational from `i_ready`.
- `o_valid` = 1 in ONE and FULL.
- Bundle order is strictly FIFO. No bundle is dropped or duplicated.
- Payload registers load only on the transfers listed above. When not loading they hold their value; no reset is needed on payload for function.
- `o_stall_cnt`: increments by 1 each cycle with `o_valid && !i_ready` and saturates at 2^CNT_W−1. No wrap.

## Timing
- Reset (async assert, released synchronously to `i_clk` by the system): state EMPTY, `o_valid`=0, `o_ready`=1, `o_a`=0, `o_c`/`o_d`/`o_e`=0, `o_stall_cnt`=0.
- Latency: a bundle accepted at edge N appears with `o_valid`=1 after edge N, in cycle N+1.
- Throughput: 1 bundle/cycle while `i_ready`=1.
- `o_ready` falls the cycle after the skid register fills. It rises the cycle after the first transfer out of FULL.
- Simultaneous in and out in ONE: main loads the new bundle and the count is unchanged. `o_valid` stays high with no bubble.
- Reset asserted mid-operation: all buffered bundles are discarded immediately and the outputs take their reset values asynchronously.
- `o_valid` and the bundle stay stable while `o_valid && !i_ready`.

## Structure
- Package `operand_pkg`:
  - `skid_state_e` enum {EMPTY, ONE, FULL}.
  - `operand_bundle_t` packed struct {a; c; d; e} parameterised by WIDTH through a package localparam default 8.
  - `STALL_CNT_MAX` helper.
- Single module, no sub-modules. The stall counter is small enough to stay inline.

## Test plan
- Reset: assert `i_arst_n`=0 mid-stream with 2 bundles buffered -> immediately `o_valid`=0, `o_ready`=1, `o_stall_cnt`=0. Nothing buffered emerges after release.
- Streaming: `i_ready`=1, send bundles c=0x01..0x10 back-to-back -> outputs c=0x01..0x10 in order, one per cycle, 1-cycle latency, `o_ready` constant 1.
- Back-pressure: send 0xA1, 0xA2, 0xA3 with `i_ready`=0 -> 0xA1 held on outputs, 0xA2 in skid, `o_ready`=0 from the cycle after 0xA2 accepted, 0xA3 not accepted. Raise `i_ready` -> 0xA1, 0xA2, 0xA3 delivered in order.
- Simultaneous in/out in ONE: main=0x55, in 0x66 while `i_ready`=1 -> next cycle outputs 0x66, `o_valid` stays 1, state ONE.
- Counter saturation: CNT_W=4, hold `o_valid`=1 with `i_ready`=0 for 20 cycles -> `o_stall_cnt`=15 and stays there.
- Random valid/ready (10k cycles) with scoreboard -> zero loss, zero duplication, order preserved, `o_ready` never low in EMPTY.
